// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler sharing one 5-bit function unit among three requesters
module alu_share_sched #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [14:0] req_a,
  input  logic [14:0] req_b,
  input  logic [5:0]  req_sel,
  input  logic [2:0]  req_cin,
  output logic [2:0]  gnt,
  output logic [4:0]  alu_a,
  output logic [4:0]  alu_b,
  output logic        alu_cin,
  output logic        alu_s1,
  output logic        alu_s0,
  input  logic [4:0]  alu_o,
  input  logic        alu_carry,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [4:0]  rsp_data,
  output logic        rsp_carry,
  output logic        busy
);
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic [2:0]  r_gnt;
  logic [1:0]  r_last;
  logic [4:0]  r_a;
  logic [4:0]  r_b;
  logic [1:0]  r_sel;
  logic        r_cin;
  logic        r_rsp_valid;
  logic [1:0]  r_rsp_id;
  logic [4:0]  r_rsp_data;
  logic        r_rsp_carry;
  logic        r_busy;
  logic [1:0]  w_c0;
  logic [1:0]  w_c1;
  logic [1:0]  w_c2;
  logic [1:0]  w_pick;
  logic        w_take;
  logic        w_done;
  // round-robin search from the requester after the last grant, plus next-state decision
  always_comb begin
    w_c0   = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_c1   = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
    w_c2   = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    w_pick = req[w_c0] ? w_c0 : req[w_c1] ? w_c1 : w_c2;
    w_take = (r_state == IDLE) && (|req);
    w_done = (r_state == DRIVE) && (r_cnt == 3'd1);
    w_next = w_take ? DRIVE : w_done ? IDLE : r_state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // grant/latch operands on take, count down while driving, capture the result on the last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_last      <= 2'd2;
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= '0;
      r_cin       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= (w_next == DRIVE);
      if (w_take) begin
        r_gnt  <= 3'b001 << w_pick;
        r_last <= w_pick;
        r_cnt  <= 3'(SETTLE);
        r_a    <= req_a[5*w_pick +: 5];
        r_b    <= req_b[5*w_pick +: 5];
        r_sel  <= req_sel[2*w_pick +: 2];
        r_cin  <= req_cin[w_pick];
      end else if (r_state == DRIVE) begin
        r_cnt <= r_cnt - 3'd1;
        if (w_done) begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_last;
          r_rsp_data  <= alu_o;
          r_rsp_carry <= alu_carry;
          r_a         <= '0;
          r_b         <= '0;
          r_sel       <= '0;
          r_cin       <= 1'b0;
        end
      end
    end
  end
  assign gnt       = r_gnt;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_s1    = r_sel[1];
  assign alu_s0    = r_sel[0];
  assign alu_cin   = r_cin;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign busy      = r_busy;
endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: two instances (SETTLE 1 and 3) checked every cycle against a schedule-level model
module tb_alu_share_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [2:0]  req [2];
  logic [14:0] ra [2];
  logic [14:0] rb [2];
  logic [5:0]  rsel [2];
  logic [2:0]  rcin [2];
  logic [2:0]  gnt [2];
  logic [4:0]  aa [2];
  logic [4:0]  ab [2];
  logic [4:0]  ao [2];
  logic [4:0]  rdata [2];
  logic        acin [2];
  logic        as1 [2];
  logic        as0 [2];
  logic        acar [2];
  logic        rv [2];
  logic        rc [2];
  logic        busy [2];
  logic [1:0]  rid [2];

  int tests = 0;
  int fails = 0;
  int n = 0;
  bit chk_en = 0;

  function automatic logic [5:0] fu(logic [4:0] a, logic [4:0] b, logic [1:0] s, logic c);
    case (s)
      2'd0:    return {1'b0, a} + {1'b0, b} + {5'b0, c};
      2'd1:    return {c, a & b};
      2'd2:    return {c, a | b};
      default: return {~c, a ^ b};
    endcase
  endfunction

  assign {acar[0], ao[0]} = fu(aa[0], ab[0], {as1[0], as0[0]}, acin[0]);
  assign {acar[1], ao[1]} = fu(aa[1], ab[1], {as1[1], as0[1]}, acin[1]);

  alu_share_sched #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .req_a(ra[0]), .req_b(rb[0]), .req_sel(rsel[0]),
    .req_cin(rcin[0]), .gnt(gnt[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_cin(acin[0]),
    .alu_s1(as1[0]), .alu_s0(as0[0]), .alu_o(ao[0]), .alu_carry(acar[0]), .rsp_valid(rv[0]),
    .rsp_id(rid[0]), .rsp_data(rdata[0]), .rsp_carry(rc[0]), .busy(busy[0]));

  alu_share_sched #(.SETTLE(3)) u3 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .req_a(ra[1]), .req_b(rb[1]), .req_sel(rsel[1]),
    .req_cin(rcin[1]), .gnt(gnt[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_cin(acin[1]),
    .alu_s1(as1[1]), .alu_s0(as0[1]), .alu_o(ao[1]), .alu_carry(acar[1]), .rsp_valid(rv[1]),
    .rsp_id(rid[1]), .rsp_data(rdata[1]), .rsp_carry(rc[1]), .busy(busy[1]));

  function automatic int sd(int d);
    return d ? 3 : 1;
  endfunction

  function automatic int pick(int last, logic [2:0] r);
    int i;
    for (int k = 1; k <= 3; k++) begin
      i = (last + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // model: each accepted operation is an edge number; everything else follows from it
  int          m_op [2]   = '{-100, -100};
  int          m_free [2] = '{0, 0};
  int          m_last [2] = '{2, 2};
  logic [4:0]  m_a [2];
  logic [4:0]  m_b [2];
  logic [1:0]  m_sel [2];
  logic        m_cin [2];
  logic [1:0]  m_id [2];
  logic [4:0]  h_data [2];
  logic        h_c [2];
  logic [1:0]  h_id [2];

  always @(posedge clk) begin
    int i;
    n++;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        m_op[d] = -100; m_last[d] = 2; m_free[d] = n + 1;
        h_data[d] = 0; h_c[d] = 0; h_id[d] = 0;
      end else begin
        if (n == m_op[d] + sd(d)) begin
          {h_c[d], h_data[d]} = fu(m_a[d], m_b[d], m_sel[d], m_cin[d]);
          h_id[d] = m_id[d];
        end
        if (n >= m_free[d] && req[d] != 3'b0) begin
          i = pick(m_last[d], req[d]);
          m_op[d] = n; m_free[d] = n + sd(d) + 1; m_last[d] = i; m_id[d] = 2'(i);
          m_a[d] = ra[d][5*i +: 5]; m_b[d] = rb[d][5*i +: 5];
          m_sel[d] = rsel[d][2*i +: 2]; m_cin[d] = rcin[d][i];
        end
      end
    end
  end

  task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d got %0h exp %0h", nm, d, n, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_en)
      for (int d = 0; d < 2; d++) begin
        logic act;
        act = (n >= m_op[d]) && (n < m_op[d] + sd(d));
        chk("gnt", d, gnt[d], (m_op[d] == n) ? 32'(3'b001 << m_id[d]) : 32'd0);
        chk("alu", d, {aa[d], ab[d], as1[d], as0[d], acin[d]},
            act ? {19'b0, m_a[d], m_b[d], m_sel[d], m_cin[d]} : 32'd0);
        chk("busy", d, busy[d], act);
        chk("rsp_valid", d, rv[d], n == m_op[d] + sd(d));
        chk("rsp", d, {rid[d], rdata[d], rc[d]}, {h_id[d], h_data[d], h_c[d]});
      end
  endtask

  task automatic wait_gnt(int d);
    int k = 0;
    do begin cycle(); k++; end while (gnt[d] == 3'b0 && k < 12);
  endtask

  task automatic wait_rsp(int d);
    int k = 0;
    do begin cycle(); k++; end while (!rv[d] && k < 12);
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [14:0] a;
    logic [14:0] b;
    logic [5:0]  sel;
    logic [2:0]  cin;
    logic [1:0]  id;
    logic [4:0]  data;
    logic        carry;
  } vec_t;
  vec_t tv [6];

  logic [2:0] gg [4];
  int         gt [4];
  int         gc;

  initial begin
    tv[0] = '{3'b001, {5'd0, 5'd0, 5'd9},   {5'd0, 5'd0, 5'd12},  6'd0,       3'b000, 2'd0, 5'd21, 1'b0};
    tv[1] = '{3'b001, {5'd0, 5'd0, 5'd31},  {5'd0, 5'd0, 5'd0},   6'd0,       3'b001, 2'd0, 5'd0,  1'b1};
    tv[2] = '{3'b110, {5'd3, 5'd10, 5'd0},  {5'd4, 5'd5, 5'd0},   6'd0,       3'b010, 2'd1, 5'd16, 1'b0};
    tv[3] = '{3'b110, {5'd3, 5'd10, 5'd0},  {5'd4, 5'd5, 5'd0},   6'd0,       3'b010, 2'd2, 5'd7,  1'b0};
    tv[4] = '{3'b101, {5'd1, 5'd0, 5'd20},  {5'd0, 5'd0, 5'd20},  6'd0,       3'b000, 2'd0, 5'd8,  1'b1};
    tv[5] = '{3'b111, {5'd0, 5'd12, 5'd0},  {5'd0, 5'd10, 5'd0},  6'b001100,  3'b000, 2'd1, 5'd6,  1'b1};
    rst = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; ra[d] = 0; rb[d] = 0; rsel[d] = 0; rcin[d] = 0;
    end
    cycle(); cycle();
    chk_en = 1;
    req[0] = 3'b111; req[1] = 3'b111;
    cycle();
    rst = 2'b00; req[0] = 0; req[1] = 0;

    for (int i = 0; i < 6; i++) begin
      req[0] = tv[i].req; ra[0] = tv[i].a; rb[0] = tv[i].b; rsel[0] = tv[i].sel; rcin[0] = tv[i].cin;
      wait_gnt(0);
      chk("tv_gnt", 0, gnt[0], 32'(3'b001 << tv[i].id));
      req[0] = 0;
      wait_rsp(0);
      chk("tv_rsp", 0, {rv[0], rid[0], rdata[0], rc[0]}, {1'b1, tv[i].id, tv[i].data, tv[i].carry});
    end

    req[1] = 3'b111; ra[1] = {5'd7, 5'd6, 5'd5}; rb[1] = {5'd1, 5'd2, 5'd3};
    gc = 0;
    for (int i = 0; i < 4; i++) begin gg[i] = 0; gt[i] = 0; end
    for (int c = 0; c < 18; c++) begin
      cycle();
      ra[1] = 15'($urandom);
      if (gnt[1] != 3'b0 && gc < 4) begin gg[gc] = gnt[1]; gt[gc] = n; gc++; end
    end
    req[1] = 0;
    for (int i = 0; i < 4; i++) chk("rr_order", 1, gg[i], 32'(3'b001 << (i % 3)));
    for (int i = 1; i < 4; i++) chk("rr_gap", 1, gt[i] - gt[i-1], 4);
    repeat (5) cycle();

    req[1] = 3'b001;
    wait_gnt(1);
    req[1] = 0;
    cycle();
    rst[1] = 1; req[1] = 3'b111;
    cycle();
    chk("abort_busy", 1, {busy[1], rv[1], gnt[1]}, 0);
    rst[1] = 0;
    wait_gnt(1);
    chk("rst_rr", 1, gnt[1], 3'b001);
    req[1] = 3'b100;
    wait_gnt(1);
    chk("after_rst_gnt2", 1, gnt[1], 3'b100);
    req[1] = 0;
    repeat (5) cycle();

    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d] = ($urandom_range(0, 59) == 0);
        req[d] = 3'($urandom); ra[d] = 15'($urandom); rb[d] = 15'($urandom);
        rsel[d] = 6'($urandom); rcin[d] = 3'($urandom);
      end
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
